// File: rtl/jmp_exec_pkg.sv
// rtl/jmp_exec_pkg.sv - shared types and constants for the jump execution pipe
package jmp_exec_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int PREG_W_DEF = 6;
  localparam int ROB_W_DEF  = 6;

  typedef enum logic [1:0] {
    CLS_JAL  = 2'd0,
    CLS_JALR = 2'd1,
    CLS_BR   = 2'd2,
    CLS_ILL  = 2'd3
  } jclass_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // The IQ does not carry an opcode; which sources are read identifies the class.
  function automatic jclass_e decode_class(input logic prs1_valid, input logic prs2_valid);
    case ({prs1_valid, prs2_valid})
      2'b00:   return CLS_JAL;
      2'b10:   return CLS_JALR;
      2'b11:   return CLS_BR;
      default: return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/jmp_exec_br_cmp.sv
// rtl/jmp_exec_br_cmp.sv - branch condition compare under funct3
module br_cmp
  import jmp_exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [2:0]      i_funct3,
  output logic            o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = (i_op1 == i_op2);
      F3_BNE:  o_taken = (i_op1 != i_op2);
      F3_BLT:  o_taken = ($signed(i_op1) <  $signed(i_op2));
      F3_BGE:  o_taken = ($signed(i_op1) >= $signed(i_op2));
      F3_BLTU: o_taken = (i_op1 <  i_op2);
      F3_BGEU: o_taken = (i_op1 >= i_op2);
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/jmp_exec.sv
// rtl/jmp_exec.sv - two-stage (RR, EX) execute pipe for JAL, JALR and branches
module jmp_exec
  import jmp_exec_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int PREG_W = PREG_W_DEF,
  parameter int ROB_W  = ROB_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [ROB_W-1:0]  iss_pos,
  input  logic [PREG_W-1:0] iss_prd,
  input  logic [PREG_W-1:0] iss_prs1,
  input  logic [PREG_W-1:0] iss_prs2,
  input  logic              iss_prs1_valid,
  input  logic              iss_prs2_valid,
  input  logic [2:0]        iss_funct3,
  input  logic [4:0]        iss_rd,
  input  logic [XLEN-1:0]   iss_pc,
  input  logic [XLEN-1:0]   iss_imm,
  input  logic              iss_alubyp1,
  input  logic              iss_alubyp2,
  input  logic              iss_jmpbyp1,
  input  logic              iss_jmpbyp2,
  output logic [PREG_W-1:0] rf_raddr1,
  output logic [PREG_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic [XLEN-1:0]   alu_res,
  output logic              wb_valid,
  output logic [PREG_W-1:0] wb_prd,
  output logic [XLEN-1:0]   wb_data,
  output logic              cmp_valid,
  output logic [ROB_W-1:0]  cmp_pos,
  output logic              redir_valid,
  output logic [XLEN-1:0]   redir_pc
);

  // RR stage
  logic              r_rr_valid;
  logic [ROB_W-1:0]  r_rr_pos;
  logic [PREG_W-1:0] r_rr_prd, r_rr_prs1, r_rr_prs2;
  logic              r_rr_prs1_valid, r_rr_prs2_valid;
  logic [2:0]        r_rr_funct3;
  logic [4:0]        r_rr_rd;
  logic [XLEN-1:0]   r_rr_pc, r_rr_imm;
  logic              r_rr_alubyp1, r_rr_alubyp2, r_rr_jmpbyp1, r_rr_jmpbyp2;

  // EX stage
  logic              r_ex_valid;
  jclass_e           r_ex_cls;
  logic [XLEN-1:0]   r_ex_op1, r_ex_op2, r_ex_pc, r_ex_imm;
  logic [2:0]        r_ex_funct3;
  logic [PREG_W-1:0] r_ex_prd;
  logic [4:0]        r_ex_rd;
  logic [ROB_W-1:0]  r_ex_pos;

  // Registered results
  logic              r_wb_valid, r_cmp_valid, r_redir_valid;
  logic [PREG_W-1:0] r_wb_prd;
  logic [XLEN-1:0]   r_wb_data, r_redir_pc;
  logic [ROB_W-1:0]  r_cmp_pos;

  logic [XLEN-1:0]   w_op1, w_op2;
  logic [XLEN-1:0]   w_jalr_sum, w_target, w_link;
  logic              w_br_taken, w_is_jump, w_taken, w_wb_en;
  logic [XLEN-1:0]   w_ex_wb_data;

  assign rf_raddr1 = r_rr_prs1;
  assign rf_raddr2 = r_rr_prs2;

  // jmpbyp reads the value EX is about to write back, so a dependent jump
  // issued the very next cycle sees the older link value.
  always_comb begin
    w_op1 = '0;
    if (!r_rr_prs1_valid)  w_op1 = '0;
    else if (r_rr_jmpbyp1) w_op1 = w_ex_wb_data;
    else if (r_rr_alubyp1) w_op1 = alu_res;
    else                   w_op1 = rf_rdata1;
  end

  always_comb begin
    w_op2 = '0;
    if (!r_rr_prs2_valid)  w_op2 = '0;
    else if (r_rr_jmpbyp2) w_op2 = w_ex_wb_data;
    else if (r_rr_alubyp2) w_op2 = alu_res;
    else                   w_op2 = rf_rdata2;
  end

  br_cmp #(.XLEN(XLEN)) u_br_cmp (
    .i_op1    (r_ex_op1),
    .i_op2    (r_ex_op2),
    .i_funct3 (r_ex_funct3),
    .o_taken  (w_br_taken)
  );

  assign w_jalr_sum   = r_ex_op1 + r_ex_imm;
  assign w_target     = (r_ex_cls == CLS_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                               : (r_ex_pc + r_ex_imm);
  assign w_link       = r_ex_pc + XLEN'(4);
  assign w_is_jump    = (r_ex_cls == CLS_JAL) || (r_ex_cls == CLS_JALR);
  assign w_taken      = r_ex_valid && (w_is_jump || ((r_ex_cls == CLS_BR) && w_br_taken));
  assign w_wb_en      = r_ex_valid && w_is_jump && (r_ex_rd != 5'd0);
  assign w_ex_wb_data = w_wb_en ? w_link : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_valid      <= 1'b0;
      r_rr_pos        <= '0;
      r_rr_prd        <= '0;
      r_rr_prs1       <= '0;
      r_rr_prs2       <= '0;
      r_rr_prs1_valid <= 1'b0;
      r_rr_prs2_valid <= 1'b0;
      r_rr_funct3     <= '0;
      r_rr_rd         <= '0;
      r_rr_pc         <= '0;
      r_rr_imm        <= '0;
      r_rr_alubyp1    <= 1'b0;
      r_rr_alubyp2    <= 1'b0;
      r_rr_jmpbyp1    <= 1'b0;
      r_rr_jmpbyp2    <= 1'b0;
      r_ex_valid      <= 1'b0;
      r_ex_cls        <= CLS_JAL;
      r_ex_op1        <= '0;
      r_ex_op2        <= '0;
      r_ex_pc         <= '0;
      r_ex_imm        <= '0;
      r_ex_funct3     <= '0;
      r_ex_prd        <= '0;
      r_ex_rd         <= '0;
      r_ex_pos        <= '0;
      r_wb_valid      <= 1'b0;
      r_wb_prd        <= '0;
      r_wb_data       <= '0;
      r_cmp_valid     <= 1'b0;
      r_cmp_pos       <= '0;
      r_redir_valid   <= 1'b0;
      r_redir_pc      <= '0;
    end else begin
      r_rr_valid      <= iss_valid && !flush;
      r_rr_pos        <= iss_pos;
      r_rr_prd        <= iss_prd;
      r_rr_prs1       <= iss_prs1;
      r_rr_prs2       <= iss_prs2;
      r_rr_prs1_valid <= iss_prs1_valid;
      r_rr_prs2_valid <= iss_prs2_valid;
      r_rr_funct3     <= iss_funct3;
      r_rr_rd         <= iss_rd;
      r_rr_pc         <= iss_pc;
      r_rr_imm        <= iss_imm;
      r_rr_alubyp1    <= iss_alubyp1;
      r_rr_alubyp2    <= iss_alubyp2;
      r_rr_jmpbyp1    <= iss_jmpbyp1;
      r_rr_jmpbyp2    <= iss_jmpbyp2;

      r_ex_valid      <= r_rr_valid && !flush;
      r_ex_cls        <= decode_class(r_rr_prs1_valid, r_rr_prs2_valid);
      r_ex_op1        <= w_op1;
      r_ex_op2        <= w_op2;
      r_ex_pc         <= r_rr_pc;
      r_ex_imm        <= r_rr_imm;
      r_ex_funct3     <= r_rr_funct3;
      r_ex_prd        <= r_rr_prd;
      r_ex_rd         <= r_rr_rd;
      r_ex_pos        <= r_rr_pos;

      // Whatever sits in EX during a flush is killed before it becomes visible.
      r_wb_valid      <= w_wb_en && !flush;
      r_wb_prd        <= (w_wb_en && !flush) ? r_ex_prd : '0;
      r_wb_data       <= flush ? '0 : w_ex_wb_data;
      r_cmp_valid     <= r_ex_valid && !flush;
      r_cmp_pos       <= (r_ex_valid && !flush) ? r_ex_pos : '0;
      r_redir_valid   <= w_taken && !flush;
      r_redir_pc      <= (w_taken && !flush) ? w_target : '0;
    end
  end

  assign wb_valid    = r_wb_valid;
  assign wb_prd      = r_wb_prd;
  assign wb_data     = r_wb_data;
  assign cmp_valid   = r_cmp_valid;
  assign cmp_pos     = r_cmp_pos;
  assign redir_valid = r_redir_valid;
  assign redir_pc    = r_redir_pc;

endmodule
